// File: rtl/float_pipe_lzc_norm.sv
// float_pipe_lzc_norm
//   Multi-lane pipelined leading-digit counter and normaliser. Each lane counts
//   how many MSB-first bits equal the counted digit (0 or 1, chosen by in_mode).
//   It returns the scaled count OUTPUT_STEP*n+OUTPUT_BIAS (mod 2^OUTPUT_WIDTH),
//   the mantissa shifted left by n, and a flag that is set when every digit
//   equals the counted digit.
// Ports
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    input handshake; in_mode and in_data sampled on transfer
//   in_mode              0: count leading zeros, 1: count leading ones
//   in_data              LANES packed mantissas, lane k at [k*INPUT_WIDTH +: INPUT_WIDTH]
//   out_valid/out_ready  output handshake with full back-pressure
//   out_cnt              per-lane scaled count
//   out_norm             per-lane left-normalised mantissa
//   out_zero             per-lane all-same-digit flag
module float_pipe_lzc_norm #(
  parameter int LANES        = 4,
  parameter int INPUT_WIDTH  = 26,
  parameter int OUTPUT_WIDTH = 5,
  parameter int OUTPUT_STEP  = 1,
  parameter int OUTPUT_BIAS  = 0,
  parameter int PIPE_STAGES  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_mode,
  input  logic [LANES*INPUT_WIDTH-1:0]  in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*OUTPUT_WIDTH-1:0] out_cnt,
  output logic [LANES*INPUT_WIDTH-1:0]  out_norm,
  output logic [LANES-1:0]              out_zero
);

  localparam int NW = $clog2(INPUT_WIDTH + 1);
  localparam int unsigned LAST = PIPE_STAGES - 1;

  typedef logic [INPUT_WIDTH-1:0]  word_t;
  typedef logic [NW-1:0]           n_t;
  typedef logic [OUTPUT_WIDTH-1:0] cnt_t;

  // Pipeline registers. Non-final stages carry the raw mantissa and its count;
  // the final stage holds the shifted mantissa.
  logic [PIPE_STAGES-1:0] v_q;
  word_t                  data_q [PIPE_STAGES][LANES];
  n_t                     n_q    [PIPE_STAGES][LANES];
  cnt_t                   cnt_q  [PIPE_STAGES][LANES];
  logic [LANES-1:0]       zero_q [PIPE_STAGES];

  // Values presented to each stage's D inputs.
  logic [PIPE_STAGES-1:0] src_v;
  word_t                  src_data [PIPE_STAGES][LANES];
  n_t                     src_n    [PIPE_STAGES][LANES];
  cnt_t                   src_cnt  [PIPE_STAGES][LANES];
  logic [LANES-1:0]       src_zero [PIPE_STAGES];

  logic [PIPE_STAGES-1:0] can_load;

  function automatic n_t lead_count(input word_t d, input logic digit);
    n_t   n;
    logic done;
    n    = '0;
    done = 1'b0;
    for (int unsigned i = 0; i < INPUT_WIDTH; i++) begin
      if (!done) begin
        if (d[INPUT_WIDTH-1-i] == digit) n = n + n_t'(1);
        else                             done = 1'b1;
      end
    end
    return n;
  endfunction

  function automatic cnt_t scale(input n_t n);
    logic [63:0] full;
    full = 64'(OUTPUT_STEP) * 64'(n) + 64'(OUTPUT_BIAS);
    return full[OUTPUT_WIDTH-1:0];
  endfunction

  // Stage i can load when it is empty, or its occupant moves on. Unrolling that
  // recursion: some stage from i to the last is empty, or the output retires.
  always_comb begin
    logic all_full;
    can_load = '0;
    all_full = 1'b0;
    for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
      all_full = 1'b1;
      for (int unsigned j = i; j < PIPE_STAGES; j++) all_full &= v_q[j];
      can_load[i] = out_ready || !all_full;
    end
  end

  always_comb begin
    n_t n;
    n     = '0;
    src_v = '0;
    for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
      src_zero[i] = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
        src_data[i][k] = '0;
        src_n[i][k]    = '0;
        src_cnt[i][k]  = '0;
      end
    end
    // Stage 0 resolves the count directly from the input beat.
    src_v[0] = in_valid;
    for (int unsigned k = 0; k < LANES; k++) begin
      n              = lead_count(in_data[k*INPUT_WIDTH +: INPUT_WIDTH], in_mode);
      src_data[0][k] = in_data[k*INPUT_WIDTH +: INPUT_WIDTH];
      src_n[0][k]    = n;
      src_cnt[0][k]  = scale(n);
      src_zero[0][k] = (n == n_t'(INPUT_WIDTH));
    end
    for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
      src_v[i]    = v_q[i-1];
      src_zero[i] = zero_q[i-1];
      for (int unsigned k = 0; k < LANES; k++) begin
        src_data[i][k] = data_q[i-1][k];
        src_n[i][k]    = n_q[i-1][k];
        src_cnt[i][k]  = cnt_q[i-1][k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
        zero_q[i] <= '0;
        for (int unsigned k = 0; k < LANES; k++) begin
          data_q[i][k] <= '0;
          n_q[i][k]    <= '0;
          cnt_q[i][k]  <= '0;
        end
      end
    end else begin
      for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
        if (can_load[i]) begin
          v_q[i] <= src_v[i];
          // Payload only moves with a valid beat, so a drained stage keeps its
          // last contents rather than loading garbage.
          if (src_v[i]) begin
            zero_q[i] <= src_zero[i];
            for (int unsigned k = 0; k < LANES; k++) begin
              // Shifting by n == INPUT_WIDTH yields zero, as required.
              data_q[i][k] <= (i == LAST) ? (src_data[i][k] << src_n[i][k])
                                          : src_data[i][k];
              n_q[i][k]    <= src_n[i][k];
              cnt_q[i][k]  <= src_cnt[i][k];
            end
          end
        end
      end
    end
  end

  always_comb begin
    in_ready  = can_load[0];
    out_valid = v_q[LAST];
    out_zero  = zero_q[LAST];
    out_cnt   = '0;
    out_norm  = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      out_cnt[k*OUTPUT_WIDTH +: OUTPUT_WIDTH] = cnt_q[LAST][k];
      out_norm[k*INPUT_WIDTH +: INPUT_WIDTH]  = data_q[LAST][k];
    end
  end

endmodule

// File: tb/tb_float_pipe_lzc_norm.sv
// Testbench for float_pipe_lzc_norm: directed vectors, queue-based scoreboard.
module tb_float_pipe_lzc_norm;
  localparam int L = 4;
  localparam int W = 26;
  localparam int P = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic           in_valid, in_valid2, in_mode, out_ready;
  logic [L*W-1:0] in_data;
  logic           in_ready, out_valid, in_ready2, out_valid2;
  logic [L*5-1:0] out_cnt;
  logic [L*6-1:0] out_cnt2;
  logic [L*W-1:0] out_norm, out_norm2;
  logic [L-1:0]   out_zero, out_zero2;

  float_pipe_lzc_norm #(
    .LANES(L), .INPUT_WIDTH(W), .OUTPUT_WIDTH(5),
    .OUTPUT_STEP(1), .OUTPUT_BIAS(0), .PIPE_STAGES(P)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_cnt(out_cnt), .out_norm(out_norm),
    .out_zero(out_zero)
  );

  float_pipe_lzc_norm #(
    .LANES(L), .INPUT_WIDTH(W), .OUTPUT_WIDTH(6),
    .OUTPUT_STEP(2), .OUTPUT_BIAS(1), .PIPE_STAGES(P)
  ) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid2),
    .out_ready(out_ready), .out_cnt(out_cnt2), .out_norm(out_norm2),
    .out_zero(out_zero2)
  );

  typedef struct {
    logic [23:0]  cnt;
    logic [103:0] norm;
    logic [3:0]   zero;
    int           acc;
    bit           lat;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   seen1 = 1'b0;
  bit   seen2 = 1'b0;
  bit   stream_done = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [103:0] act, input logic [103:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [23:0] c, input logic [103:0] n,
                              input logic [3:0] z, input bit lat);
    exp_t e;
    e.cnt = c; e.norm = n; e.zero = z; e.acc = 0; e.lat = lat;
    return e;
  endfunction

  // Monitors: compare whatever the DUT presents against the queue front; pop
  // only when the beat actually retires, so stalls are checked every cycle.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_beat actual=cnt %h norm %h required=no beat", out_cnt, out_norm);
      end else begin
        chk("cnt", out_cnt, q1[0].cnt[19:0]);
        chk("norm", out_norm, q1[0].norm);
        chk("zero", out_zero, q1[0].zero);
        if (!seen1 && q1[0].lat) chk("latency", cyc - q1[0].acc, P);
        seen1 = 1'b1;
        if (out_ready) begin
          void'(q1.pop_front());
          seen1 = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid2) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_beat2 actual=cnt %h required=no beat", out_cnt2);
      end else begin
        chk("cnt2", out_cnt2, q2[0].cnt);
        chk("norm2", out_norm2, q2[0].norm);
        chk("zero2", out_zero2, q2[0].zero);
        if (!seen2 && q2[0].lat) chk("latency2", cyc - q2[0].acc, P);
        seen2 = 1'b1;
        if (out_ready) begin
          void'(q2.pop_front());
          seen2 = 1'b0;
        end
      end
    end
  end

  // Call at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic send(input bit sel, input logic m, input logic [103:0] d, input exp_t e);
    bit   ok;
    logic rdy;
    int   acc;
    ok = 1'b0;
    if (sel) in_valid2 = 1'b1; else in_valid = 1'b1;
    in_mode = m;
    in_data = d;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      rdy = sel ? in_ready2 : in_ready;
      acc = cyc;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        e.acc = acc;
        if (sel) q2.push_back(e); else q1.push_back(e);
      end
    end
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=in_ready low 100 cycles required=accept");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (q1.size() != 0 || q2.size() != 0); i++) @(posedge clk);
    #1;
    if (q1.size() != 0 || q2.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d/%0d pending required=0", q1.size(), q2.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0; in_mode = 1'b0;
    in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_out_norm", out_norm, 0);
    chk("rst_out_zero", out_zero, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // T1 / T2 / T3 back to back at full rate with exact latency.
    send(0, 1'b0, {26'h00F0F0F, 26'h0400000, 26'h2000000, 26'h0000001},
         mk({4'b0, 5'd6, 5'd3, 5'd0, 5'd25},
            {26'h3C3C3C0, 26'h2000000, 26'h2000000, 26'h2000000}, 4'b0000, 1));
    send(0, 1'b0, '0, mk({4'b0, {4{5'd26}}}, '0, 4'b1111, 1));
    send(0, 1'b1, {26'h2AAAAAA, 26'h0000000, 26'h3FFFFFF, 26'h3A00000},
         mk({4'b0, 5'd1, 5'd0, 5'd26, 5'd3},
            {26'h1555554, 26'h0000000, 26'h0000000, 26'h1000000}, 4'b0010, 1));
    drain();

    // T4: scaled and biased count on the second instance.
    send(1, 1'b0, {4{26'h0800000}}, mk({4{6'd5}}, {4{26'h2000000}}, 4'b0000, 1));
    send(1, 1'b0, '0, mk({4{6'd53}}, '0, 4'b1111, 1));
    drain();

    // T5: 8 one-hot / one-cold beats with a 4-cycle output stall mid-stream.
    stream_done = 1'b0;
    fork
      begin
        for (int j = 0; j < 8; j++) begin
          logic [103:0] d, nrm;
          logic [23:0]  c;
          logic [25:0]  one, v;
          int           p;
          one = 26'd1; d = '0; nrm = '0; c = '0;
          for (int k = 0; k < 4; k++) begin
            p = (j * 7 + k * 5) % 26;
            v = one << p;
            d[k*26 +: 26]   = (j % 2 == 1) ? ~v : v;
            c[k*5 +: 5]     = 5'(25 - p);
            nrm[k*26 +: 26] = (j % 2 == 1) ? ((v - one) << (25 - p)) : (one << 25);
          end
          send(0, 1'(j % 2), d, mk(c, nrm, 4'b0000, 0));
        end
        stream_done = 1'b1;
      end
      begin
        repeat (3) @(posedge clk);
        #2;
        out_ready = 1'b0;
        repeat (4) @(negedge clk);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && !stream_done; i++) begin
          @(negedge clk);
          if (!stream_done) chk("no_bubble", out_valid, 1);
        end
      end
    join
    drain();

    // T6: reset with two beats held in the pipe.
    out_ready = 1'b0;
    send(0, 1'b0, {4{26'h0000001}}, mk({4'b0, {4{5'd25}}}, {4{26'h2000000}}, 4'b0000, 0));
    send(0, 1'b0, '0, mk({4'b0, {4{5'd26}}}, '0, 4'b1111, 0));
    @(posedge clk);
    #1;
    chk("held_out_valid", out_valid, 1);
    rst = 1'b1;
    q1.delete();
    seen1 = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_cnt", out_cnt, 0);
    chk("midrst_out_norm", out_norm, 0);
    chk("midrst_out_zero", out_zero, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("postrst_in_ready", in_ready, 1);
    repeat (4) @(posedge clk);
    #1;
    send(0, 1'b0, {26'h0000003, 26'h1000000, 26'h0000100, 26'h0080000},
         mk({4'b0, 5'd24, 5'd1, 5'd17, 5'd6},
            {26'h3000000, 26'h2000000, 26'h2000000, 26'h2000000}, 4'b0000, 1));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
